// File: rtl/multi_vc_packet_injector_pkg.sv
// Shared types and helpers for the multi-VC packet injector.
// Flit flag bundle and index-width function used by the top and the arbiter.
package multi_vc_packet_injector_pkg;

  typedef struct packed {
    logic hdr;
    logic tail;
  } flit_flags_t;

  // Index width for n items, never below one bit so V=1 still elaborates.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/multi_vc_packet_injector_rr_arbiter.sv
// Round-robin VC arbiter with optional packet lock.
// Grant depends only on registered request state and the internal pointer/lock.
module injector_rr_arbiter
  import multi_vc_packet_injector_pkg::*;
#(
  parameter int V    = 4,
  parameter int LOCK = 0
)(
  input  logic         clk,
  input  logic         reset,
  input  logic [V-1:0] req,
  input  logic         lock_set,
  input  logic         lock_clr,
  output logic [V-1:0] grant
);

  localparam int PW = log2(V);

  logic [PW-1:0] ptr_q, ptr_d, j;
  logic [V-1:0]  lvc_q, lvc_d, req_m;
  logic          lock_q, lock_d, found;

  always_comb begin
    req_m = lock_q ? (req & lvc_q) : req;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < V; i++) begin
      j = PW'((int'(ptr_q) + i) % V);
      if (!found && req_m[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        ptr_d    = PW'((int'(j) + 1) % V);
      end
    end
  end

  // A locked VC with no credit masks every other request.
  always_comb begin
    lock_d = lock_q;
    lvc_d  = lvc_q;
    if (LOCK != 0 && found) begin
      if (lock_set) begin
        lock_d = 1'b1;
        lvc_d  = grant;
      end
      if (lock_clr) lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      lvc_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= lock_d;
      lvc_q  <= lvc_d;
    end
  end

endmodule

// File: rtl/multi_vc_packet_injector.sv
// Multi-VC packet injector: one descriptor FSM and credit counter per VC,
// feeding a single NoC local port through a round-robin VC arbiter.
module multi_vc_packet_injector
  import multi_vc_packet_injector_pkg::*;
#(
  parameter int V        = 4,
  parameter int Fpay     = 32,
  parameter int PCK_SIZw = 8,
  parameter int LB       = 4,
  parameter int CRDTw    = 4,
  parameter int PCK_LOCK = 0
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [V-1:0]          pck_wr,
  input  logic [V*PCK_SIZw-1:0] pck_size,
  input  logic [V*Fpay-1:0]     pck_hdr,
  input  logic [V*Fpay-1:0]     pck_seed,
  output logic [V-1:0]          pck_ready,
  input  logic [V-1:0]          credit_in,
  output logic                  flit_wr,
  output logic [V-1:0]          flit_vc,
  output logic                  flit_hdr,
  output logic                  flit_tail,
  output logic [Fpay-1:0]       flit_payload,
  output logic [V*CRDTw-1:0]    credit_cnt,
  output logic [31:0]           flit_total
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [PCK_SIZw-1:0] S1  = PCK_SIZw'(1);
  localparam logic [CRDTw-1:0]    C1  = CRDTw'(1);
  localparam logic [CRDTw-1:0]    LBC = CRDTw'(LB);

  typedef struct packed {
    logic [Fpay-1:0] hdr;
    logic [Fpay-1:0] seed;
  } desc_t;

  logic [V-1:0]    elig, grant;
  flit_flags_t     flg [V];
  logic [Fpay-1:0] pay [V];
  logic [31:0]     tot_q, tot_d;

  for (genvar v = 0; v < V; v++) begin : g_vc
    logic [0:0]          st_q, st_d;
    desc_t               desc_q, desc_d;
    logic [PCK_SIZw-1:0] rem_q, rem_d, idx_q, idx_d, sz;
    logic [CRDTw-1:0]    cr_q, cr_d;
    logic                acc, snd, crd;

    assign sz  = pck_size[v*PCK_SIZw +: PCK_SIZw];
    assign acc = pck_wr[v] & (st_q == IDLE);
    assign snd = grant[v];
    assign crd = credit_in[v];

    always_comb begin
      st_d   = st_q;
      desc_d = desc_q;
      rem_d  = rem_q;
      idx_d  = idx_q;
      if (acc) begin
        st_d        = ACTIVE;
        desc_d.hdr  = pck_hdr[v*Fpay +: Fpay];
        desc_d.seed = pck_seed[v*Fpay +: Fpay];
        rem_d       = (sz == '0) ? S1 : sz;
        idx_d       = '0;
      end else if (snd) begin
        idx_d = idx_q + S1;
        rem_d = rem_q - S1;
        if (rem_q == S1) st_d = IDLE;
      end
    end

    // Send and return in the same cycle cancel; overflow saturates at LB.
    always_comb begin
      cr_d = cr_q;
      if (snd && !crd) cr_d = cr_q - C1;
      else if (crd && !snd && cr_q != LBC) cr_d = cr_q + C1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= IDLE;
        desc_q <= '0;
        rem_q  <= '0;
        idx_q  <= '0;
        cr_q   <= LBC;
      end else begin
        st_q   <= st_d;
        desc_q <= desc_d;
        rem_q  <= rem_d;
        idx_q  <= idx_d;
        cr_q   <= cr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (!(pck_wr[v] && st_q != IDLE))
          else $error("vc%0d: descriptor write while busy", v);
        assert (!(acc && sz == '0))
          else $error("vc%0d: zero packet size", v);
        assert (!(crd && !snd && cr_q == LBC))
          else $error("vc%0d: credit overflow", v);
      end
    end

    assign elig[v]      = (st_q == ACTIVE) && (cr_q != '0);
    assign pck_ready[v] = (st_q == IDLE);
    assign credit_cnt[v*CRDTw +: CRDTw] = cr_q;
    assign flg[v] = '{hdr: (idx_q == '0), tail: (rem_q == S1)};
    assign pay[v] = (idx_q == '0) ? desc_q.hdr
                                  : desc_q.seed + Fpay'(idx_q);
  end

  injector_rr_arbiter #(
    .V    (V),
    .LOCK (PCK_LOCK)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (elig),
    .lock_set (flit_hdr & ~flit_tail),
    .lock_clr (flit_tail),
    .grant    (grant)
  );

  always_comb begin
    flit_wr      = |grant;
    flit_vc      = grant;
    flit_hdr     = 1'b0;
    flit_tail    = 1'b0;
    flit_payload = '0;
    for (int i = 0; i < V; i++) begin
      if (grant[i]) begin
        flit_hdr     = flg[i].hdr;
        flit_tail    = flg[i].tail;
        flit_payload = pay[i];
      end
    end
    tot_d = flit_wr ? tot_q + 32'd1 : tot_q;
  end

  always_ff @(posedge clk) begin
    if (reset) tot_q <= '0;
    else       tot_q <= tot_d;
  end

  assign flit_total = tot_q;

endmodule
